fu_wb_arbiter: RTL and testbench
================================

// Module: fu_wb_arbiter
// PURPOSE
//  Parametrised write-back arbiter between NR_FU execute-stage functional units and NR_WB_PORTS
//  scoreboard write ports. Each FU result (data, trans_id, exception) enters a per-FU FIFO;
//  a round-robin arbiter drains up to NR_WB_PORTS FIFO heads per cycle onto the write ports.
//  Replaces the single shared FLU write port and its fixed-priority result mux.
// PARAMETERS
//  NR_FU        4   number of FU input channels (>=2)
//  NR_WB_PORTS  2   scoreboard write ports (1..NR_FU)
//  DATA_W       64  result width
//  TRANS_ID_W   3   trans_id width (= TRANS_ID_BITS)
//  FIFO_DEPTH   2   entries per FU FIFO (power of two, >=1)
// PORTS
//  clk_i          in  1                    clock
//  rst_i          in  1                    async reset, active-high
//  flush_i        in  1                    drop all buffered results
//  fu_valid_i     in  NR_FU                FU result valid
//  fu_ready_o     out NR_FU                FIFO can accept (count < FIFO_DEPTH)
//  fu_data_i      in  NR_FU*DATA_W         FU results, channel i at [i*DATA_W +: DATA_W]
//  fu_trans_id_i  in  NR_FU*TRANS_ID_W     scoreboard IDs
//  fu_ex_valid_i  in  NR_FU                exception raised
//  fu_ex_cause_i  in  NR_FU*DATA_W         exception cause
//  wb_valid_o     out NR_WB_PORTS          write port valid (scoreboard always accepts)
//  wb_data_o      out NR_WB_PORTS*DATA_W   result
//  wb_trans_id_o  out NR_WB_PORTS*TRANS_ID_W
//  wb_ex_valid_o  out NR_WB_PORTS
//  wb_ex_cause_o  out NR_WB_PORTS*DATA_W
//  busy_o         out 1                    any FIFO non-empty
// BEHAVIOUR
//  - Reset: all FIFO counts/pointers 0, rr_ptr 0; fu_ready_o all 1; wb_valid_o 0, busy_o 0;
//    wb data/id/ex outputs 0 while corresponding wb_valid_o is 0.
//  - Push: fu_valid_i[i] & fu_ready_o[i] writes entry at clock edge. fu_ready_o depends only on
//    registered count: a full FIFO that pops this cycle still shows ready=0 this cycle.
//    fu_valid_i while ready=0 is dropped and is a protocol error (assertion).
//  - Wb outputs are combinational from FIFO heads; latency push-edge -> wb_valid_o = 1 cycle,
//    no same-cycle bypass from fu_*_i to wb_*_o.
//  - Arbitration: scan channels rr_ptr, rr_ptr+1, ... (mod NR_FU); first non-empty -> lane 0,
//    next -> lane 1, up to NR_WB_PORTS grants; unused lanes valid=0. Lanes are filled densely.
//  - Granted FIFOs pop at the clock edge; one pop per FIFO per cycle max.
//  - rr_ptr <= (index of last granted channel + 1) mod NR_FU if any grant, else unchanged.
//  - Push and pop on same FIFO same cycle: count unchanged, order preserved (FIFO).
//  - Pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
//  - flush_i: wb_valid_o forced 0 that cycle, no pops; at edge all counts/pointers -> 0, pushes
//    in the flush cycle discarded; rr_ptr retained. fu_ready_o=1 for all the next cycle.
//  - Reset asserted mid-operation: state cleared asynchronously, buffered results lost.
//  - busy_o = OR of (count != 0), registered-state based.
//  - Fairness: a channel with a non-empty FIFO is granted within ceil(NR_FU/NR_WB_PORTS) cycles.
// TESTING (defaults unless stated)
//  1 push FU2 data=0x1234 id=5 at cycle 0 -> cycle 1 wb_valid_o=2'b01, lane0 data 0x1234 id 5,
//    cycle 2 wb_valid_o=0, busy_o=0, rr_ptr=3.
//  2 all 4 FUs push ids 0..3 at cycle 0 -> cycle 1 lanes {id0,id1}, cycle 2 {id2,id3}, rr_ptr=0.
//  3 NR_WB_PORTS=1, all FUs push every cycle -> fu_ready_o drops on FIFOs reaching 2, one id per
//    cycle in order FU0,1,2,3,0..., no result lost or duplicated (scoreboard model).
//  4 FU1 pushes ex_valid=1 cause=0x2 id 4 -> lane ex_valid=1 cause 0x2 id 4 one cycle later.
//  5 fill FIFOs with 5 entries, assert flush_i 1 cycle with concurrent push -> wb_valid_o=0 in
//    flush cycle and after, busy_o=0, fu_ready_o=4'b1111 next cycle.
//  6 rst_i pulse mid-traffic -> outputs to reset values immediately, new push after release
//    returns at lane0 one cycle later.

Source files
------------

// File: rtl/fu_wb_arbiter_if.sv
// Bundle between the execute-stage FUs / scoreboard (master) and the write-back arbiter (slave).
// Channel i occupies bits [i*W +: W] of every packed multi-channel field.
interface fu_wb_arbiter_if #(
    parameter int NR_FU       = 4,
    parameter int NR_WB_PORTS = 2,
    parameter int DATA_W      = 64,
    parameter int TRANS_ID_W  = 3
);
    logic                              flush;
    logic [NR_FU-1:0]                  fu_valid;
    logic [NR_FU-1:0]                  fu_ready;
    logic [NR_FU*DATA_W-1:0]           fu_data;
    logic [NR_FU*TRANS_ID_W-1:0]       fu_trans_id;
    logic [NR_FU-1:0]                  fu_ex_valid;
    logic [NR_FU*DATA_W-1:0]           fu_ex_cause;
    logic [NR_WB_PORTS-1:0]            wb_valid;
    logic [NR_WB_PORTS*DATA_W-1:0]     wb_data;
    logic [NR_WB_PORTS*TRANS_ID_W-1:0] wb_trans_id;
    logic [NR_WB_PORTS-1:0]            wb_ex_valid;
    logic [NR_WB_PORTS*DATA_W-1:0]     wb_ex_cause;
    logic                              busy;

    modport master (
        output flush, fu_valid, fu_data, fu_trans_id, fu_ex_valid, fu_ex_cause,
        input  fu_ready, wb_valid, wb_data, wb_trans_id, wb_ex_valid, wb_ex_cause, busy
    );

    modport slave (
        input  flush, fu_valid, fu_data, fu_trans_id, fu_ex_valid, fu_ex_cause,
        output fu_ready, wb_valid, wb_data, wb_trans_id, wb_ex_valid, wb_ex_cause, busy
    );
endinterface

// File: rtl/fu_wb_arbiter.sv
// Write-back arbiter: one small FIFO per functional unit, round-robin drain of up to
// NR_WB_PORTS FIFO heads per cycle onto the scoreboard write ports.
module fu_wb_arbiter #(
    parameter int NR_FU       = 4,
    parameter int NR_WB_PORTS = 2,
    parameter int DATA_W      = 64,
    parameter int TRANS_ID_W  = 3,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fu_wb_arbiter_if.slave   bus
);
    localparam int RR_W  = (NR_FU > 1) ? $clog2(NR_FU) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [TRANS_ID_W-1:0] trans_id;
        logic                  ex_valid;
        logic [DATA_W-1:0]     ex_cause;
    } entry_t;

    entry_t            mem [NR_FU][FIFO_DEPTH];
    entry_t            fu_entry [NR_FU];
    entry_t            head [NR_FU];
    logic [CNT_W-1:0]  count_reg [NR_FU];
    logic [PTR_W-1:0]  wr_ptr_reg [NR_FU];
    logic [PTR_W-1:0]  rd_ptr_reg [NR_FU];
    logic [RR_W-1:0]   rr_ptr_reg;
    logic [RR_W-1:0]   rr_ptr_next;
    logic [NR_FU-1:0]  ready;
    logic [NR_FU-1:0]  nonempty;
    logic [NR_FU-1:0]  push;
    logic [NR_FU-1:0]  pop;
    logic              any_grant;
    logic [NR_WB_PORTS-1:0] lane_valid;
    logic [RR_W-1:0]   lane_ch [NR_WB_PORTS];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NR_FU; gi++) begin : g_ch
            // Ready looks only at the registered count, never at this cycle's pop.
            assign ready[gi]    = (count_reg[gi] != CNT_W'(FIFO_DEPTH));
            assign nonempty[gi] = (count_reg[gi] != '0);
            assign push[gi]     = bus.fu_valid[gi] & ready[gi] & ~bus.flush;
            assign fu_entry[gi] = '{data:     bus.fu_data[gi*DATA_W +: DATA_W],
                                    trans_id: bus.fu_trans_id[gi*TRANS_ID_W +: TRANS_ID_W],
                                    ex_valid: bus.fu_ex_valid[gi],
                                    ex_cause: bus.fu_ex_cause[gi*DATA_W +: DATA_W]};
            assign head[gi]     = mem[gi][rd_ptr_reg[gi]];
        end
    endgenerate

    // Walk channels starting at rr_ptr, handing non-empty ones to lanes in order.
    always_comb begin
        int ch;
        int n_grant;
        pop         = '0;
        lane_valid  = '0;
        any_grant   = 1'b0;
        rr_ptr_next = rr_ptr_reg;
        n_grant     = 0;
        for (int l = 0; l < NR_WB_PORTS; l++) begin
            lane_ch[l] = '0;
        end
        for (int k = 0; k < NR_FU; k++) begin
            ch = int'(rr_ptr_reg) + k;
            if (ch >= NR_FU) begin
                ch = ch - NR_FU;
            end
            if (!bus.flush && nonempty[RR_W'(ch)] && n_grant < NR_WB_PORTS) begin
                pop[RR_W'(ch)] = 1'b1;
                for (int l = 0; l < NR_WB_PORTS; l++) begin
                    if (l == n_grant) begin
                        lane_valid[l] = 1'b1;
                        lane_ch[l]    = RR_W'(ch);
                    end
                end
                any_grant   = 1'b1;
                rr_ptr_next = (ch == NR_FU - 1) ? '0 : RR_W'(ch + 1);
                n_grant     = n_grant + 1;
            end
        end
    end

    always_comb begin
        entry_t e;
        bus.wb_valid    = lane_valid;
        bus.wb_data     = '0;
        bus.wb_trans_id = '0;
        bus.wb_ex_valid = '0;
        bus.wb_ex_cause = '0;
        for (int l = 0; l < NR_WB_PORTS; l++) begin
            e = head[lane_ch[l]];
            if (lane_valid[l]) begin
                bus.wb_data[l*DATA_W +: DATA_W]             = e.data;
                bus.wb_trans_id[l*TRANS_ID_W +: TRANS_ID_W] = e.trans_id;
                bus.wb_ex_valid[l]                          = e.ex_valid;
                bus.wb_ex_cause[l*DATA_W +: DATA_W]         = e.ex_cause;
            end
        end
    end

    assign bus.fu_ready = ready;
    assign bus.busy     = |nonempty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_FU; i++) begin
                count_reg[i]  <= '0;
                wr_ptr_reg[i] <= '0;
                rd_ptr_reg[i] <= '0;
            end
            rr_ptr_reg <= '0;
        end else begin
            for (int i = 0; i < NR_FU; i++) begin
                if (bus.flush) begin
                    count_reg[i]  <= '0;
                    wr_ptr_reg[i] <= '0;
                    rd_ptr_reg[i] <= '0;
                end else begin
                    if (push[i]) wr_ptr_reg[i] <= ptr_inc(wr_ptr_reg[i]);
                    if (pop[i])  rd_ptr_reg[i] <= ptr_inc(rd_ptr_reg[i]);
                    count_reg[i] <= count_reg[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
                end
            end
            if (any_grant) rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_FU; i++) begin
            if (push[i]) mem[i][wr_ptr_reg[i]] <= fu_entry[i];
        end
    end

    a_no_drop: assert property (@(posedge clk_i) disable iff (rst_i)
                                (bus.fu_valid & ~ready) == '0);
endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed bench: default arbiter (2 write ports) plus a single-port instance for the
// saturation scoreboard run.
module tb_fu_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fu_wb_arbiter_if #(.NR_FU(4), .NR_WB_PORTS(2), .DATA_W(64), .TRANS_ID_W(3)) bus_a ();
    fu_wb_arbiter_if #(.NR_FU(4), .NR_WB_PORTS(1), .DATA_W(64), .TRANS_ID_W(3)) bus_b ();

    fu_wb_arbiter #(.NR_FU(4), .NR_WB_PORTS(2), .DATA_W(64), .TRANS_ID_W(3), .FIFO_DEPTH(2))
        dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a.slave));
    fu_wb_arbiter #(.NR_FU(4), .NR_WB_PORTS(1), .DATA_W(64), .TRANS_ID_W(3), .FIFO_DEPTH(2))
        dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b.slave));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.flush       = 1'b0;
        bus_a.fu_valid    = '0;
        bus_a.fu_data     = '0;
        bus_a.fu_trans_id = '0;
        bus_a.fu_ex_valid = '0;
        bus_a.fu_ex_cause = '0;
    endtask

    task automatic push_all_a();
        bus_a.fu_valid    = 4'hF;
        bus_a.fu_trans_id = {3'd3, 3'd2, 3'd1, 3'd0};
        bus_a.fu_data     = {64'h1003, 64'h1002, 64'h1001, 64'h1000};
    endtask

    logic [63:0] q [4][$];
    int          seq [4];
    int          rr_m;
    int          pushed;
    int          popped;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_a();
        bus_b.flush       = 1'b0;
        bus_b.fu_valid    = '0;
        bus_b.fu_data     = '0;
        bus_b.fu_trans_id = '0;
        bus_b.fu_ex_valid = '0;
        bus_b.fu_ex_cause = '0;

        #23;
        check("rst ready_a", bus_a.fu_ready, 4'hF);
        check("rst ready_b", bus_b.fu_ready, 4'hF);
        check("rst wb_valid", bus_a.wb_valid, 2'b00);
        check("rst busy", bus_a.busy, 1'b0);
        check("rst wb_data", bus_a.wb_data, 128'h0);
        rst = 1'b0;
        tick();

        // all four FUs at once, rr_ptr starts at 0
        push_all_a();
        check("t2 no bypass", bus_a.wb_valid, 2'b00);
        tick();
        idle_a();
        check("t2 c1 valid", bus_a.wb_valid, 2'b11);
        check("t2 c1 lane0 id", bus_a.wb_trans_id[2:0], 3'd0);
        check("t2 c1 lane1 id", bus_a.wb_trans_id[5:3], 3'd1);
        check("t2 c1 lane1 data", bus_a.wb_data[127:64], 64'h1001);
        tick();
        check("t2 c2 valid", bus_a.wb_valid, 2'b11);
        check("t2 c2 lane0 id", bus_a.wb_trans_id[2:0], 3'd2);
        check("t2 c2 lane1 id", bus_a.wb_trans_id[5:3], 3'd3);
        tick();
        check("t2 c3 valid", bus_a.wb_valid, 2'b00);
        check("t2 c3 busy", bus_a.busy, 1'b0);

        // single FU2 result
        bus_a.fu_valid          = 4'b0100;
        bus_a.fu_data[128 +: 64] = 64'h1234;
        bus_a.fu_trans_id[6 +: 3] = 3'd5;
        tick();
        idle_a();
        check("t1 valid", bus_a.wb_valid, 2'b01);
        check("t1 lane0 data", bus_a.wb_data[63:0], 64'h1234);
        check("t1 lane0 id", bus_a.wb_trans_id[2:0], 3'd5);
        check("t1 lane1 data", bus_a.wb_data[127:64], 64'h0);
        check("t1 busy", bus_a.busy, 1'b1);
        tick();
        check("t1 drained valid", bus_a.wb_valid, 2'b00);
        check("t1 drained busy", bus_a.busy, 1'b0);

        // rr_ptr is now 3: FU3 must win lane 0 over FU0
        bus_a.fu_valid          = 4'b1001;
        bus_a.fu_trans_id[0 +: 3] = 3'd1;
        bus_a.fu_trans_id[9 +: 3] = 3'd2;
        tick();
        idle_a();
        check("rr valid", bus_a.wb_valid, 2'b11);
        check("rr lane0 id(FU3)", bus_a.wb_trans_id[2:0], 3'd2);
        check("rr lane1 id(FU0)", bus_a.wb_trans_id[5:3], 3'd1);
        tick();

        // exception on FU1
        bus_a.fu_valid             = 4'b0010;
        bus_a.fu_data[64 +: 64]    = 64'h55;
        bus_a.fu_trans_id[3 +: 3]  = 3'd4;
        bus_a.fu_ex_valid          = 4'b0010;
        bus_a.fu_ex_cause[64 +: 64] = 64'h2;
        tick();
        idle_a();
        check("t4 valid", bus_a.wb_valid, 2'b01);
        check("t4 ex_valid", bus_a.wb_ex_valid, 2'b01);
        check("t4 cause", bus_a.wb_ex_cause[63:0], 64'h2);
        check("t4 id", bus_a.wb_trans_id[2:0], 3'd4);
        check("t4 lane1 cause", bus_a.wb_ex_cause[127:64], 64'h0);
        tick();

        // fill to 5 entries (rr_ptr=2), then flush with a concurrent push
        push_all_a();
        tick();
        bus_a.fu_valid = 4'b0111;
        check("t5 ready c2", bus_a.fu_ready, 4'hF);
        tick();
        idle_a();
        check("t5 ready full", bus_a.fu_ready, 4'b1100);
        check("t5 busy", bus_a.busy, 1'b1);
        check("t5 pre-flush valid", bus_a.wb_valid, 2'b11);
        bus_a.flush    = 1'b1;
        bus_a.fu_valid = 4'b1000;
        #1;
        check("t5 flush-cycle valid", bus_a.wb_valid, 2'b00);
        tick();
        idle_a();
        check("t5 post valid", bus_a.wb_valid, 2'b00);
        check("t5 post busy", bus_a.busy, 1'b0);
        check("t5 post ready", bus_a.fu_ready, 4'hF);
        tick();
        check("t5 push discarded", bus_a.wb_valid, 2'b00);

        // single write port, FUs push whenever ready; bench-side queue model
        rr_m = 0; pushed = 0; popped = 0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        for (int cyc = 0; cyc < 48; cyc++) begin
            logic [3:0]  exp_rdy;
            logic [63:0] d;
            int          g;
            int          c;
            for (int i = 0; i < 4; i++) exp_rdy[i] = (q[i].size() < 2);
            check($sformatf("t3 c%0d ready", cyc), bus_b.fu_ready, exp_rdy);
            g = -1;
            for (int k = 0; k < 4; k++) begin
                c = (rr_m + k) % 4;
                if (g < 0 && q[c].size() != 0) g = c;
            end
            check($sformatf("t3 c%0d valid", cyc), bus_b.wb_valid, (g >= 0));
            if (g >= 0) begin
                check($sformatf("t3 c%0d data", cyc), bus_b.wb_data, q[g][0]);
                void'(q[g].pop_front());
                rr_m = (g + 1) % 4;
                popped++;
            end
            bus_b.fu_valid = (cyc < 24) ? exp_rdy : 4'b0000;
            for (int i = 0; i < 4; i++) begin
                if (bus_b.fu_valid[i]) begin
                    d = (64'(i) << 32) | 64'(seq[i]);
                    bus_b.fu_data[i*64 +: 64] = d;
                    q[i].push_back(d);
                    seq[i]++;
                    pushed++;
                end
            end
            tick();
        end
        check("t3 popped==pushed", 128'(popped), 128'(pushed));
        check("t3 busy end", bus_b.busy, 1'b0);

        // asynchronous reset in the middle of traffic
        push_all_a();
        tick();
        idle_a();
        check("t6 pre-rst valid", bus_a.wb_valid, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        check("t6 rst valid", bus_a.wb_valid, 2'b00);
        check("t6 rst busy", bus_a.busy, 1'b0);
        check("t6 rst ready", bus_a.fu_ready, 4'hF);
        check("t6 rst data", bus_a.wb_data, 128'h0);
        #2;
        rst = 1'b0;
        tick();
        bus_a.fu_valid            = 4'b0010;
        bus_a.fu_data[64 +: 64]   = 64'hABC;
        bus_a.fu_trans_id[3 +: 3] = 3'd6;
        tick();
        idle_a();
        check("t6 after valid", bus_a.wb_valid, 2'b01);
        check("t6 after id", bus_a.wb_trans_id[2:0], 3'd6);
        check("t6 after data", bus_a.wb_data[63:0], 64'hABC);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
